// File: rtl/trng_pkg.sv
// trng_pkg: shared types and constants for the TRNG seed collector.
// Collector FSM states, word constants and the whitening rotate helper.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RELEASE,
        ST_DONE,
        ST_FAIL
    } trng_state_e;

    localparam int TRNG_WORD_W = 32;

    localparam logic [TRNG_WORD_W-1:0] TRNG_ALL0 = '0;
    localparam logic [TRNG_WORD_W-1:0] TRNG_ALL1 = '1;

    localparam int WHITEN_ROT = 7;

    function automatic logic [TRNG_WORD_W-1:0] rotl_w(
        input logic [TRNG_WORD_W-1:0] w
    );
        return {w[TRNG_WORD_W-1-WHITEN_ROT:0],
                w[TRNG_WORD_W-1:TRNG_WORD_W-WHITEN_ROT]};
    endfunction

endpackage

// File: rtl/trng_health_check.sv
// trng_health_check: combinational accept/reject of one raw TRNG word.
// in: raw_word, prev_word, prev_vld; out: accept (0 = stuck or repeated).
module trng_health_check
    import trng_pkg::*;
(
    input  logic [TRNG_WORD_W-1:0] raw_word,
    input  logic [TRNG_WORD_W-1:0] prev_word,
    input  logic                   prev_vld,
    output logic                   accept
);

    logic stuck;
    logic repeated;

    always_comb begin
        stuck    = (raw_word == TRNG_ALL0)
                 | (raw_word == TRNG_ALL1);
        repeated = prev_vld & (raw_word == prev_word);
        accept   = ~(stuck | repeated);
    end

endmodule

// File: rtl/trng_seed_collector.sv
// trng_seed_collector: gathers WORDS health-checked TRNG words into a seed.
// in: clk, rst_n, seed_req, health_clr, trng_ready, random_number
// out: seed_valid, seed_data, health_fail, trng_request
// Optional TRNG_SEED_WHITEN_EN: store raw ^ rotl7(previous accepted raw).
module trng_seed_collector
    import trng_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter int REP_LIMIT = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         seed_req,
    output logic                         seed_valid,
    output logic [TRNG_WORD_W*WORDS-1:0] seed_data,
    output logic                         health_fail,
    input  logic                         health_clr,
    output logic                         trng_request,
    input  logic                         trng_ready,
    input  logic [TRNG_WORD_W-1:0]       random_number
);

    localparam int SW = TRNG_WORD_W * WORDS;
    localparam int CW = $clog2(WORDS + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);

    localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
    localparam logic [RW-1:0] REP_C   = RW'(REP_LIMIT);

    trng_state_e            state_q, state_d;
    logic                   req_q, req_d;
    logic                   valid_q, valid_d;
    logic                   fail_q, fail_d;
    logic [SW-1:0]          buf_q, buf_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          rej_q, rej_d;
    logic [TRNG_WORD_W-1:0] prev_q, prev_d;
    logic                   pvld_q, pvld_d;

    logic [RW-1:0]          rej_inc;
    logic [TRNG_WORD_W-1:0] store_w;
    logic                   accept;

    trng_health_check u_hc (
        .raw_word  (random_number),
        .prev_word (prev_q),
        .prev_vld  (pvld_q),
        .accept    (accept)
    );

`ifdef TRNG_SEED_WHITEN_EN
    // Previous accepted raw word of the current seed; ignored for slot 0.
    logic [TRNG_WORD_W-1:0] acc_q, acc_d;

    always_comb begin
        store_w = random_number;
        if (cnt_q != '0) begin
            store_w = random_number ^ rotl_w(acc_q);
        end
    end
`else
    always_comb begin
        store_w = random_number;
    end
`endif

    // Saturating: holds at REP_LIMIT instead of wrapping.
    always_comb begin
        rej_inc = rej_q;
        if (rej_q != REP_C) begin
            rej_inc = rej_q + RW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        valid_d = valid_q;
        fail_d  = fail_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        rej_d   = rej_q;
        prev_d  = prev_q;
        pvld_d  = pvld_q;
`ifdef TRNG_SEED_WHITEN_EN
        acc_d   = acc_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                req_d  = 1'b0;
                cnt_d  = '0;
                pvld_d = 1'b0;
                if (seed_req && !trng_ready && !fail_q) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (!seed_req) begin
                    // Abort beats a word arriving this cycle.
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    buf_d   = '0;
                    pvld_d  = 1'b0;
                end else if (trng_ready) begin
                    req_d  = 1'b0;
                    prev_d = random_number;
                    pvld_d = 1'b1;
                    if (accept) begin
                        for (int i = 0; i < WORDS; i++) begin
                            if (cnt_q == CW'(i)) begin
                                buf_d[i*TRNG_WORD_W +: TRNG_WORD_W]
                                    = store_w;
                            end
                        end
                        cnt_d   = cnt_q + CW'(1);
                        rej_d   = '0;
                        state_d = ST_RELEASE;
`ifdef TRNG_SEED_WHITEN_EN
                        acc_d   = random_number;
`endif
                    end else begin
                        rej_d = rej_inc;
                        if (rej_inc == REP_C) begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
            end
            ST_RELEASE: begin
                if (!seed_req) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    buf_d   = '0;
                    pvld_d  = 1'b0;
                end else if (!trng_ready) begin
                    if (cnt_q == WORDS_C) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!seed_req) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_FAIL: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                if (health_clr) begin
                    state_d = ST_IDLE;
                    fail_d  = 1'b0;
                    rej_d   = '0;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
            rej_q   <= '0;
            prev_q  <= '0;
            pvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            fail_q  <= fail_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            rej_q   <= rej_d;
            prev_q  <= prev_d;
            pvld_q  <= pvld_d;
        end
    end

`ifdef TRNG_SEED_WHITEN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    assign trng_request = req_q;
    assign seed_valid   = valid_q;
    assign health_fail  = fail_q;
    assign seed_data    = buf_q;

endmodule

// File: tb/tb_trng_seed_collector.sv
// tb_trng_seed_collector: scoreboard bench for trng_seed_collector.
// Behavioural TRNG driven on negedge; expected seeds queued per test.
module tb_trng_seed_collector;

    localparam int WORDS = 8;
    localparam int REP   = 3;
    localparam int SW    = 32 * WORDS;

`ifdef TRNG_SEED_WHITEN_EN
    localparam logic [31:0] WH_S1 = 32'h0000_0082;
`else
    localparam logic [31:0] WH_S1 = 32'h0000_0002;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          seed_req = 1'b0;
    logic          health_clr = 1'b0;
    logic          trng_ready = 1'b0;
    logic [31:0]   random_number = '0;
    logic          seed_valid;
    logic [SW-1:0] seed_data;
    logic          health_fail;
    logic          trng_request;

    trng_seed_collector #(
        .WORDS     (WORDS),
        .REP_LIMIT (REP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seed_req      (seed_req),
        .seed_valid    (seed_valid),
        .seed_data     (seed_data),
        .health_fail   (health_fail),
        .health_clr    (health_clr),
        .trng_request  (trng_request),
        .trng_ready    (trng_ready),
        .random_number (random_number)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0]   src_q[$];
    logic [SW-1:0] exp_q[$];

    int   lat_cfg  = 33;
    int   hold_cfg = 1;
    int   lat_n    = 0;
    int   rel_n    = 0;
    int   served   = 0;
    int   rises    = 0;
    logic req_prev = 1'b0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] whiten(input logic [31:0] raw,
                                           input logic [31:0] prev,
                                           input bit first);
`ifdef TRNG_SEED_WHITEN_EN
        if (first) return raw;
        return raw ^ {prev[24:0], prev[31:25]};
`else
        return raw;
`endif
    endfunction

    task automatic push_seed(input logic [31:0] w[WORDS]);
        logic [SW-1:0] s;
        s = '0;
        for (int i = 0; i < WORDS; i++) begin
            s[i*32 +: 32] = whiten(w[i], (i == 0) ? 32'h0 : w[i-1],
                                   (i == 0));
        end
        exp_q.push_back(s);
    endtask

    // Behavioural TRNG: ready after lat_cfg cycles of request,
    // dropped hold_cfg cycles after request falls.
    task automatic trng_step();
        if (trng_request) begin
            rel_n = 0;
            if (!trng_ready) begin
                lat_n++;
                if (lat_n >= lat_cfg && src_q.size() > 0) begin
                    random_number = src_q.pop_front();
                    trng_ready = 1'b1;
                    served++;
                    lat_n = 0;
                end
            end
        end else begin
            lat_n = 0;
            if (trng_ready) begin
                rel_n++;
                if (rel_n >= hold_cfg) begin
                    trng_ready = 1'b0;
                    rel_n = 0;
                    random_number = $urandom;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        trng_step();
        if (trng_request && !req_prev) rises++;
        req_prev = trng_request;
    endtask

    task automatic collect(input string tag, input int budget);
        int n;
        logic [SW-1:0] e;
        n = 0;
        seed_req = 1'b1;
        while (!seed_valid && n < budget) begin
            tick();
            n++;
        end
        if (!seed_valid) begin
            check({tag, "_timeout"}, 32'(seed_valid), 32'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < WORDS; i++) begin
                check($sformatf("%s_s%0d", tag, i),
                      seed_data[i*32 +: 32], e[i*32 +: 32]);
            end
        end
    endtask

    task automatic release_seed(input string tag);
        seed_req = 1'b0;
        tick();
        check({tag, "_rel_valid"}, 32'(seed_valid), 32'd0);
    endtask

    task automatic wait_served(input int target, input int budget);
        int n;
        n = 0;
        while (served < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_served", 32'(served), 32'(target));
    endtask

    initial begin
        logic [31:0] w[WORDS];
        int n;

        tick();
        tick();
        check("rst_req", 32'(trng_request), 32'd0);
        check("rst_valid", 32'(seed_valid), 32'd0);
        check("rst_hf", 32'(health_fail), 32'd0);
        check("rst_data", 32'(|seed_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Nominal seed with slow TRNG.
        lat_cfg = 33;
        for (int i = 0; i < WORDS; i++) begin
            w[i] = 32'h1111_1111 * (i + 1);
            src_q.push_back(w[i]);
        end
        push_seed(w);
        rises = 0;
        seed_req = 1'b1;
        tick();
        check("idle_to_req", 32'(trng_request), 32'd1);
        collect("nom", 600);
        check("nom_rises", 32'(rises), 32'd8);
        check("nom_hf", 32'(health_fail), 32'd0);
        release_seed("nom");

        // Repeated word dropped.
        lat_cfg = 3;
        src_q.push_back(32'hA5A5_A5A5);
        src_q.push_back(32'hA5A5_A5A5);
        src_q.push_back(32'h1234_5678);
        w[0] = 32'hA5A5_A5A5;
        w[1] = 32'h1234_5678;
        for (int i = 2; i < WORDS; i++) begin
            w[i] = 32'h0101_0101 * (i + 1);
            src_q.push_back(w[i]);
        end
        push_seed(w);
        collect("rep", 400);
        check("rep_hf", 32'(health_fail), 32'd0);
        release_seed("rep");

        // Three stuck words trip the alarm.
        repeat (REP) src_q.push_back(32'h0);
        seed_req = 1'b1;
        n = 0;
        while (!health_fail && n < 200) begin
            tick();
            n++;
        end
        check("hf_set", 32'(health_fail), 32'd1);
        check("hf_req", 32'(trng_request), 32'd0);
        repeat (10) tick();
        check("hf_ign_req", 32'(trng_request), 32'd0);
        check("hf_ign_valid", 32'(seed_valid), 32'd0);
        check("hf_sticky", 32'(health_fail), 32'd1);
        seed_req = 1'b0;
        health_clr = 1'b1;
        tick();
        health_clr = 1'b0;
        check("hf_clr", 32'(health_fail), 32'd0);
        check("hf_buf", 32'(|seed_data), 32'd0);
        tick();

        // Abort coincident with the third word arriving.
        lat_cfg = 4;
        hold_cfg = 3;
        served = 0;
        for (int i = 1; i <= 3; i++) src_q.push_back(32'h1000_0000 + i);
        for (int i = 0; i < WORDS; i++) begin
            w[i] = 32'h2000_0001 + i;
            src_q.push_back(w[i]);
        end
        push_seed(w);
        seed_req = 1'b1;
        wait_served(3, 300);
        seed_req = 1'b0;
        tick();
        check("abort_req", 32'(trng_request), 32'd0);
        check("abort_buf", 32'(|seed_data), 32'd0);
        check("abort_valid", 32'(seed_valid), 32'd0);
        seed_req = 1'b1;
        tick();
        check("abort_wait", 32'(trng_request), 32'd0);
        collect("abort", 500);
        release_seed("abort");
        hold_cfg = 1;

        // Asynchronous reset mid-collection.
        lat_cfg = 3;
        served = 0;
        for (int i = 0; i < WORDS; i++) src_q.push_back(32'h3000_0001 + i);
        seed_req = 1'b1;
        wait_served(3, 300);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(trng_request), 32'd0);
        check("arst_data", 32'(|seed_data), 32'd0);
        check("arst_valid", 32'(seed_valid), 32'd0);
        check("arst_hf", 32'(health_fail), 32'd0);
        seed_req = 1'b0;
        src_q.delete();
        trng_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Whitening stimulus (raw store when the option is off).
        for (int i = 0; i < WORDS; i++) begin
            w[i] = 32'(i + 1);
            src_q.push_back(w[i]);
        end
        push_seed(w);
        collect("wh", 400);
        check("wh_s0k", seed_data[31:0], 32'h0000_0001);
        check("wh_s1k", seed_data[63:32], WH_S1);
        release_seed("wh");

        check("sb_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trng_seed_collector.md
# trng_seed_collector

Consumer-side controller for the TRNG `trng_request`/`ready` handshake. It drives the request line and captures each 32-bit `random_number`. Every word passes online health checks before it is accepted. The block assembles `WORDS` accepted words into one seed and presents that seed to a downstream user (e.g. key generation) with a level request/valid handshake.

## Interface
- `WORDS`, 8: accepted 32-bit words per seed (≥2).
- `REP_LIMIT`, 3: consecutive rejected words that trigger the health failure state (≥1).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `seed_req`  in  1  level request from the consumer; hold high until `seed_valid`, drop to release.
- `seed_valid`  out  1  seed complete; held while `seed_req` stays high.
- `seed_data`  out  32*WORDS  word i at bits [32i+31:32i]; word 0 is the first word accepted.
- `health_fail`  out  1  sticky health alarm.
- `health_clr`  in  1  single-cycle pulse that clears the alarm.
- `trng_request`  out  1  level request to the TRNG.
- `trng_ready`  in  1  TRNG word valid; high until a cycle after `trng_request` drops.
- `random_number`  in  32  TRNG word; valid while `trng_ready` is high.

## Operation
- FSM states: IDLE, REQ, RELEASE, DONE, FAIL. All outputs are registered.
- **IDLE**: `trng_request`=0 and the word count is 0.
  - Go to REQ only when `seed_req`=1, `trng_ready`=0 and `health_fail`=0.
- **REQ**: `trng_request`=1. On the first cycle with `trng_ready`=1, evaluate `random_number`.
  - Reject the word if it is 0x00000000, 0xFFFFFFFF, or equal to the previously evaluated raw word. The previous word is invalid after IDLE.
  - On accept: write the word to slot[count], increment count, clear the reject counter.
  - On reject: increment the reject counter. If it reaches `REP_LIMIT`, go to FAIL.
  - Otherwise `trng_request`←0 and go to RELEASE.
- **RELEASE**: `trng_request`=0. Wait for `trng_ready`=0.
  - Then go to DONE if count==`WORDS`, else back to REQ.
- **DONE**: `seed_valid`=1 and `seed_data` is stable. When `seed_req`=0, clear `seed_valid`, clear the count and go to IDLE.
- **FAIL**: `health_fail`=1, `trng_request`=0 and `seed_valid`=0.
  - A `health_clr` pulse clears the alarm, the reject counter and the buffer, then goes to IDLE.
  - `seed_req` is ignored in FAIL.
- **Abort**: `seed_req`=0 in REQ or RELEASE goes to IDLE next cycle with `trng_request`=0, count cleared and buffer zeroed. A partial seed is never exposed.
- **Simultaneous events**:
  - `trng_ready` rising and `seed_req` falling in the same cycle: the abort wins and the word is discarded.
  - `health_clr` outside FAIL: ignored.
- Width rules:
  - Count width is $clog2(`WORDS`+1).
  - Reject counter width is $clog2(`REP_LIMIT`+1); it saturates and never wraps.

## Timing
- Reset values: `trng_request`=0, `seed_valid`=0, `seed_data`=0, `health_fail`=0, FSM=IDLE, counters=0.
- `seed_req` high in IDLE with `trng_ready` low gives `trng_request`=1 on the next edge.
- Each word costs the TRNG latency + 1 capture cycle + ≥1 cycle in RELEASE waiting for `trng_ready` to fall.
- `seed_valid` rises one cycle after RELEASE sees `trng_ready`=0 for the final word.
- `seed_valid` falls one cycle after `seed_req` falls.
- `health_fail` rises on the edge that evaluates the `REP_LIMIT`-th consecutive reject.

## Configuration
- `TRNG_SEED_WHITEN_EN` defined: the stored word is raw XOR rotl7(previous accepted raw word). For the first word of a seed the previous word is 0, so it is stored raw. Health checks always run on raw words.
- Undefined: raw words are stored unchanged.

## Structure
- Shared package `trng_pkg`:
  - state enum;
  - constants `TRNG_WORD_W`=32, `TRNG_ALL0`, `TRNG_ALL1`, `WHITEN_ROT`=7.
- Sub-module `trng_health_check`: combinational accept/reject from the raw word, the previous word and a previous-valid flag. It is instantiated once.

## Test plan
- **Nominal seed**: behavioural TRNG returns 0x11111111..0x88888888 with `ready` 33 cycles after request; `seed_req`=1 (macro off).
  - `seed_valid`=1 with `seed_data`[31:0]=0x11111111 and [255:224]=0x88888888.
  - `trng_request` is low for ≥1 cycle between words.
- **Repetition reject**: TRNG returns 0xA5A5A5A5 twice, then 0x12345678.
  - The second word is dropped; slot1=0x12345678; `health_fail` stays 0.
- **Health fail**: with `REP_LIMIT`=3, the TRNG returns 0x00000000 three times.
  - `health_fail`=1 and `trng_request`=0; `seed_req` is ignored.
  - A `health_clr` pulse returns to IDLE and `seed_data`=0.
- **Abort**: drop `seed_req` mid-word 3, coincident with `trng_ready` rising.
  - Next cycle: `trng_request`=0, buffer zeroed.
  - Re-request waits for `trng_ready`=0, then slot0 is the next fresh word.
- **Release / reset**:
  - After `seed_valid`, drop `seed_req`: `seed_valid`=0 on the next edge.
  - Assert `rst_n`=0 mid-collection: all outputs return to reset values asynchronously.
- **Whitening** (macro on): raw words 0x00000001 then 0x00000002.
  - slot0=0x00000001, slot1=0x00000002^0x00000080=0x00000082.
